// File: rtl/fpnew_pkg.sv
// Minimal slice of the FPNew package: only the exception-status type used by the result buffer.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_rob_pkg.sv
// Shared types and constants for the FPNew in-order result buffer.
package fpnew_rob_pkg;

  localparam int unsigned STATUS_W = 5;

  typedef fpnew_pkg::status_t status_t;

  // Pointers carry one extra wrap bit above the slot index.
  function automatic int unsigned ptr_width(input int unsigned tag_width);
    return tag_width + 1;
  endfunction

endpackage

// File: rtl/fpnew_rob_ptr.sv
// Wrap-bit pointer register for the result buffer; clear wins over increment.
module fpnew_rob_ptr
  import fpnew_rob_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              inc_i,
  input  logic                              clr_i,
  output logic [ptr_width(TAG_WIDTH)-1:0]   ptr_o
);

  localparam int unsigned PW = ptr_width(TAG_WIDTH);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fpnew_rob.sv
// In-order result buffer around FPNew: tags on issue, out-of-order completion, in-order retire.
// Optional exception-flag accumulator enabled by FPNEW_ROB_FFLAGS_EN.
module fpnew_rob
  import fpnew_rob_pkg::*;
#(
  parameter int unsigned FLEN      = 64,
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  output logic [TAG_WIDTH-1:0]  issue_tag_o,
  input  logic                  cmp_valid_i,
  output logic                  cmp_ready_o,
  input  logic [TAG_WIDTH-1:0]  cmp_tag_i,
  input  logic [FLEN-1:0]       cmp_result_i,
  input  fpnew_pkg::status_t    cmp_status_i,
  output logic                  ret_valid_o,
  input  logic                  ret_ready_i,
  output logic [FLEN-1:0]       ret_result_o,
  output logic [STATUS_W-1:0]   ret_status_o,
  input  logic                  flush_i,
  output logic [TAG_WIDTH:0]    count_o,
  output logic                  busy_o,
`ifdef FPNEW_ROB_FFLAGS_EN
  input  logic                  fflags_clr_i,
  output logic [STATUS_W-1:0]   fflags_o,
`endif
  output logic                  err_o
);

  localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
  localparam int unsigned PW    = ptr_width(TAG_WIDTH);

  logic [PW-1:0]        head_q, tail_q;
  logic [TAG_WIDTH-1:0] head_idx, tail_idx;
  logic                 full;
  logic                 issue_fire, ret_fire, cmp_ok;

  logic [DEPTH-1:0]                alloc_q, alloc_d;
  logic [DEPTH-1:0]                done_q, done_d;
  logic [DEPTH-1:0][FLEN-1:0]      result_q;
  logic [DEPTH-1:0][STATUS_W-1:0]  status_q;
  logic                            err_q;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);

  assign issue_ready_o = !full;
  assign issue_tag_o   = tail_idx;
  assign cmp_ready_o   = 1'b1;
  assign ret_valid_o   = alloc_q[head_idx] && done_q[head_idx];
  assign ret_result_o  = result_q[head_idx];
  assign ret_status_o  = status_q[head_idx];
  assign count_o       = tail_q - head_q;
  assign busy_o        = (count_o != '0);
  assign err_o         = err_q;

  // Flush masks every fire so neither pointers nor slot bits see a stale event.
  assign issue_fire = issue_valid_i && issue_ready_o && !flush_i;
  assign ret_fire   = ret_valid_o && ret_ready_i && !flush_i;
  assign cmp_ok     = cmp_valid_i && !flush_i && alloc_q[cmp_tag_i] && !done_q[cmp_tag_i];

  fpnew_rob_ptr #(.TAG_WIDTH(TAG_WIDTH)) u_head_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ret_fire),
    .clr_i  (flush_i),
    .ptr_o  (head_q)
  );

  fpnew_rob_ptr #(.TAG_WIDTH(TAG_WIDTH)) u_tail_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (issue_fire),
    .clr_i  (flush_i),
    .ptr_o  (tail_q)
  );

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    if (flush_i) begin
      alloc_d = '0;
      done_d  = '0;
    end else begin
      if (ret_fire) begin
        alloc_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
      end
      if (issue_fire) begin
        alloc_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
      end
      if (cmp_ok) begin
        done_d[cmp_tag_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      if (cmp_ok) begin
        result_q[cmp_tag_i] <= cmp_result_i;
        status_q[cmp_tag_i] <= cmp_status_i;
      end
      if (cmp_valid_i && !flush_i && !cmp_ok) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef FPNEW_ROB_FFLAGS_EN
  logic [STATUS_W-1:0] fflags_q, fflags_d;

  // Clear and retire together leave only the retiring status.
  always_comb begin
    fflags_d = fflags_clr_i ? '0 : fflags_q;
    if (ret_fire) begin
      fflags_d = fflags_d | ret_status_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_fpnew_rob.sv
// Self-checking bench for fpnew_rob: directed scenarios plus randomized traffic against a queue model.
module tb_fpnew_rob;

  localparam int unsigned FLEN  = 64;
  localparam int unsigned TW    = 2;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [TW-1:0]   issue_tag;
  logic            cmp_valid = 1'b0;
  logic            cmp_ready;
  logic [TW-1:0]   cmp_tag = '0;
  logic [FLEN-1:0] cmp_result = '0;
  logic [4:0]      cmp_status = '0;
  logic            ret_valid;
  logic            ret_ready = 1'b0;
  logic [FLEN-1:0] ret_result;
  logic [4:0]      ret_status;
  logic            flush = 1'b0;
  logic [TW:0]     count;
  logic            busy;
  logic            err;
  logic            ff_clr = 1'b0;
`ifdef FPNEW_ROB_FFLAGS_EN
  logic [4:0]      fflags;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of live tags plus per-tag completion data.
  int              m_q[$];
  bit              m_done[DEPTH];
  logic [FLEN-1:0] m_res[DEPTH];
  logic [4:0]      m_st[DEPTH];
  int              m_tail;
  bit              m_err;
  logic [4:0]      m_ff;

  fpnew_rob #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_tag_o   (issue_tag),
    .cmp_valid_i   (cmp_valid),
    .cmp_ready_o   (cmp_ready),
    .cmp_tag_i     (cmp_tag),
    .cmp_result_i  (cmp_result),
    .cmp_status_i  (cmp_status),
    .ret_valid_o   (ret_valid),
    .ret_ready_i   (ret_ready),
    .ret_result_o  (ret_result),
    .ret_status_o  (ret_status),
    .flush_i       (flush),
    .count_o       (count),
    .busy_o        (busy),
`ifdef FPNEW_ROB_FFLAGS_EN
    .fflags_clr_i  (ff_clr),
    .fflags_o      (fflags),
`endif
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_done[i] = 1'b0;
      m_res[i]  = '0;
      m_st[i]   = '0;
    end
    m_tail = 0;
    m_err  = 1'b0;
    m_ff   = '0;
  endtask

  function automatic bit live(input int t);
    foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit cok, rf, isf;
    int ht;
    if (flush) begin
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
      m_tail = 0;
      if (ff_clr) m_ff = '0;
      return;
    end
    cok = cmp_valid && live(int'(cmp_tag)) && !m_done[cmp_tag];
    rf  = (m_q.size() > 0) && m_done[m_q[0]] && ret_ready;
    isf = issue_valid && (m_q.size() < DEPTH);
    if (cmp_valid && !cok) m_err = 1'b1;
    if (rf) begin
      ht = m_q.pop_front();
      m_done[ht] = 1'b0;
      m_ff = (ff_clr ? 5'b0 : m_ff) | m_st[ht];
    end else if (ff_clr) begin
      m_ff = '0;
    end
    if (cok) begin
      m_done[cmp_tag] = 1'b1;
      m_res[cmp_tag]  = cmp_result;
      m_st[cmp_tag]   = cmp_status;
    end
    if (isf) begin
      m_q.push_back(m_tail % DEPTH);
      m_done[m_tail % DEPTH] = 1'b0;
      m_tail = (m_tail + 1) % (2 * DEPTH);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    cmp_valid   = 1'b0;
    ret_ready   = 1'b0;
    flush       = 1'b0;
    ff_clr      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic complete(input int t, input logic [4:0] st);
    cmp_valid  = 1'b1;
    cmp_tag    = TW'(t);
    cmp_result = 64'hA0 + 64'(t);
    cmp_status = st;
    tick();
    cmp_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", issue_ready); end
    total++; if (issue_tag !== 2'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", issue_tag); end
    total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL reset_ret_valid got=%0b exp=0", ret_valid); end
    total++; if (ret_result !== 64'd0 || ret_status !== 5'd0) begin bad++; $display("FAIL reset_ret_data got=%0h/%0h exp=0/0", ret_result, ret_status); end
    total++; if (count !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_count got=%0d/%0b exp=0/0", count, busy); end
    total++; if (err !== 1'b0 || cmp_ready !== 1'b1) begin bad++; $display("FAIL reset_err_cmpready got=%0b/%0b exp=0/1", err, cmp_ready); end
    #1 rst_n = 1'b1;
    tick();
    issue_valid = 1'b1;
    tick();
    tick();
    issue_valid = 1'b0;
    total++; if (count !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL pre_async_count got=%0d/%0b exp=2/1", count, busy); end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (count !== 3'd0 || issue_tag !== 2'd0) begin bad++; $display("FAIL async_reset got=%0d/%0d exp=0/0", count, issue_tag); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_order();
    int ctags[4] = '{2, 0, 3, 1};
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (issue_ready !== 1'b1 || issue_tag !== TW'(i)) begin bad++; $display("FAIL issue_tag got=%0b/%0d exp=1/%0d", issue_ready, issue_tag, i); end
      tick();
    end
    total++; if (issue_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_state got=%0b/%0d exp=0/4", issue_ready, count); end
    tick();
    issue_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fifth_issue_held got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      complete(ctags[i], 5'(i + 1));
      if (i == 1) begin
        total++; if (ret_valid !== 1'b1) begin bad++; $display("FAIL head_done_valid got=%0b exp=1", ret_valid); end
      end
    end
    ret_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (ret_valid !== 1'b1 || ret_result !== 64'hA0 + 64'(k)) begin bad++; $display("FAIL retire_order got=%0b/%0h exp=1/%0h", ret_valid, ret_result, 64'hA0 + 64'(k)); end
      tick();
    end
    ret_ready = 1'b0;
    total++; if (ret_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL drained got=%0b/%0d exp=0/0", ret_valid, count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) complete(i, 5'd0);
    issue_valid = 1'b1;
    ret_ready   = 1'b1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL wrap_blocked got=%0b exp=0", issue_ready); end
    tick();
    ret_ready = 1'b0;
    total++; if (issue_ready !== 1'b1 || issue_tag !== 2'd0 || count !== 3'd3) begin bad++; $display("FAIL wrap_ready got=%0b/%0d/%0d exp=1/0/3", issue_ready, issue_tag, count); end
    tick();
    issue_valid = 1'b0;
    total++; if (count !== 3'd4 || issue_ready !== 1'b0) begin bad++; $display("FAIL wrap_refill got=%0d/%0b exp=4/0", count, issue_ready); end
  endtask

  task automatic test_err();
    do_reset();
    issue_valid = 1'b1;
    tick();
    tick();
    issue_valid = 1'b0;
    complete(3, 5'd0);
    total++; if (err !== 1'b1 || ret_valid !== 1'b0 || count !== 3'd2) begin bad++; $display("FAIL err_unalloc got=%0b/%0b/%0d exp=1/0/2", err, ret_valid, count); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", err); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    issue_valid = 1'b0;
    complete(1, 5'd0);
    total++; if (ret_valid !== 1'b0 || count !== 3'd3) begin bad++; $display("FAIL pre_flush got=%0b/%0d exp=0/3", ret_valid, count); end
    flush     = 1'b1;
    ret_ready = 1'b1;
    complete(0, 5'd0);
    flush     = 1'b0;
    ret_ready = 1'b0;
    total++; if (count !== 3'd0 || ret_valid !== 1'b0 || err !== 1'b0 || issue_tag !== 2'd0) begin bad++; $display("FAIL flush got=%0d/%0b/%0b/%0d exp=0/0/0/0", count, ret_valid, err, issue_tag); end
  endtask

`ifdef FPNEW_ROB_FFLAGS_EN
  task automatic test_fflags();
    do_reset();
    issue_valid = 1'b1;
    tick();
    tick();
    issue_valid = 1'b0;
    complete(0, 5'b00001);
    complete(1, 5'b10000);
    ret_ready = 1'b1;
    tick();
    tick();
    ret_ready = 1'b0;
    total++; if (fflags !== 5'b10001) begin bad++; $display("FAIL fflags_acc got=%0b exp=10001", fflags); end
    ff_clr = 1'b1;
    tick();
    ff_clr = 1'b0;
    total++; if (fflags !== 5'b00000) begin bad++; $display("FAIL fflags_clr got=%0b exp=0", fflags); end
  endtask
`endif

  task automatic test_random();
    int pend[$];
    bit exp_valid;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      issue_valid = ($urandom_range(0, 99) < 60);
      ret_ready   = ($urandom_range(0, 99) < 65);
      flush       = ($urandom_range(0, 99) < 3);
      ff_clr      = ($urandom_range(0, 99) < 8);
      pend.delete();
      foreach (m_q[i]) if (!m_done[m_q[i]]) pend.push_back(m_q[i]);
      cmp_valid  = 1'b0;
      cmp_result = {$urandom, $urandom};
      cmp_status = 5'($urandom);
      if (pend.size() > 0 && $urandom_range(0, 99) < 60) begin
        cmp_valid = 1'b1;
        cmp_tag   = TW'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if ($urandom_range(0, 99) < 4) begin
        cmp_valid = 1'b1;
        cmp_tag   = TW'($urandom);
      end
      exp_valid = (m_q.size() > 0) && m_done[m_q[0]];
      total++; if (ret_valid !== exp_valid) begin bad++; $display("FAIL rnd_ret_valid cyc=%0d got=%0b exp=%0b", cyc, ret_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (ret_result !== m_res[m_q[0]] || ret_status !== m_st[m_q[0]]) begin bad++; $display("FAIL rnd_ret_data cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, ret_result, ret_status, m_res[m_q[0]], m_st[m_q[0]]); end
      end
      total++; if (count !== (TW+1)'(m_q.size()) || busy !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%0b exp=%0d", cyc, count, busy, m_q.size()); end
      total++; if (issue_ready !== (m_q.size() < DEPTH) || issue_tag !== TW'(m_tail % DEPTH)) begin bad++; $display("FAIL rnd_issue cyc=%0d got=%0b/%0d exp=%0b/%0d", cyc, issue_ready, issue_tag, m_q.size() < DEPTH, m_tail % DEPTH); end
      total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err, m_err); end
`ifdef FPNEW_ROB_FFLAGS_EN
      total++; if (fflags !== m_ff) begin bad++; $display("FAIL rnd_fflags cyc=%0d got=%0b exp=%0b", cyc, fflags, m_ff); end
`endif
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_wrap();
    test_err();
    test_flush();
`ifdef FPNEW_ROB_FFLAGS_EN
    test_fflags();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpnew_rob.md
# fpnew_rob

In-order result buffer wrapped around the FPNew pipeline. Hands out tags on issue (driven into the unit's `tag_i`) and accepts completions by tag, possibly out of order across op groups. Retires results strictly in issue order to the integer/register-file writeback stage. Sits between the FP issue logic and writeback, alongside the FPNew blackbox.

## Interface
Parameters:
- `FLEN`, 64: result width.
- `TAG_WIDTH`, 2: tag width; buffer depth is `DEPTH = 2**TAG_WIDTH`.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: upstream wants to issue one op to FPNew.
- `issue_ready_o` out 1: a buffer slot is free.
- `issue_tag_o` out TAG_WIDTH: tag for this issue; valid whenever `issue_ready_o` is high.
- `cmp_valid_i` in 1: FPNew `out_valid_o`.
- `cmp_ready_o` out 1: constant 1; the buffer never stalls FPNew.
- `cmp_tag_i` in TAG_WIDTH: FPNew `tag_o`.
- `cmp_result_i` in FLEN: FPNew `result_o`.
- `cmp_status_i` in fpnew_pkg::status_t (5b: NV,DZ,OF,UF,NX): FPNew `status_o`.
- `ret_valid_o` out 1: head entry complete.
- `ret_ready_i` in 1: writeback accepts.
- `ret_result_o` out FLEN: head result.
- `ret_status_o` out 5: head status.
- `flush_i` in 1: drop all entries; asserted in the same cycle as FPNew `flush_i`.
- `count_o` out TAG_WIDTH+1: allocated entries.
- `busy_o` out 1: `count_o != 0`.
- `err_o` out 1: sticky; a completion hit an unallocated or already-done slot.
- `fflags_o` out 5: only with `FPNEW_ROB_FFLAGS_EN`.
- `fflags_clr_i` in 1: only with `FPNEW_ROB_FFLAGS_EN`.

## Operation
- State per slot: `alloc` bit, `done` bit, result, status.
- Pointers `head` (retire) and `tail` (allocate) are TAG_WIDTH+1 bits; the MSB is the wrap bit.
- Empty: `head == tail`. Full: index bits equal and MSBs differ.
- Issue fires on `issue_valid_i && issue_ready_o`:
  - `issue_tag_o = tail[TAG_WIDTH-1:0]`.
  - Set `alloc`, clear `done`, increment `tail`.
  - `issue_ready_o = !full`, from registered state only; it does not depend on same-cycle retire.
- Completion on `cmp_valid_i`:
  - If slot `cmp_tag_i` has `alloc && !done`: write result and status, set `done`.
  - Otherwise: drop the data and set `err_o`.
- Retire fires on `ret_valid_o && ret_ready_i`:
  - `ret_valid_o = alloc[head] && done[head]`; data comes straight from slot registers.
  - Clear `alloc` and `done` for the slot, increment `head`.
- Issue, completion and retire may occur in the same cycle, including on the same slot index:
  - Retire and issue on the same index while full is impossible, because issue is blocked when full.
  - A completion and a retire on different slots are independent.
- `count_o = tail - head`, modulo 2^(TAG_WIDTH+1).
- `flush_i` has priority over issue, completion and retire in that cycle:
  - Clear all `alloc`/`done` bits; set `head = tail = 0`.
  - Do not fire retire that cycle.
  - Any completion in the flush cycle is dropped and does not set `err_o`.
  - `err_o` and `fflags_o` are unaffected.
- Reset values: `issue_ready_o=1`, `issue_tag_o=0`, `ret_valid_o=0`, `ret_result_o=0`, `ret_status_o=0`, `count_o=0`, `busy_o=0`, `err_o=0`, `fflags_o=0`. Slot data resets to 0.

## Timing
- Completion to retire: a completion captured at edge N gives `ret_valid_o` high in cycle N+1 at the earliest. There is no bypass path.
- Issue to `count_o`: updated after the edge.
- Full to not-full: a retire at edge N raises `issue_ready_o` in cycle N+1.
- Back-to-back retire: one per cycle when consecutive slots are done.
- No combinational path from any input to `issue_ready_o`, `ret_valid_o` or `ret_*`. `cmp_ready_o` is constant.
- Reset mid-operation: all state returns to reset values asynchronously; pending FPNew results must be discarded by FPNew reset.

## Configuration
- `FPNEW_ROB_FFLAGS_EN` defined:
  - Adds `fflags_o` and `fflags_clr_i`.
  - On each retire, `fflags_o <= fflags_o | ret_status_o`.
  - `fflags_clr_i` zeroes it; if clear and retire occur in the same cycle, the result is the retiring status only.
- Undefined: the ports are absent and the accumulator logic is not generated.

## Structure
- Package `fpnew_rob_pkg`:
  - `ptr_t` (TAG_WIDTH+1 bits) helper width function.
  - `STATUS_W = 5`.
  - Status comes from `fpnew_pkg::status_t`.
- Sub-module `fpnew_rob_ptr`: wrap-bit pointer register with increment and clear, instantiated for head and tail.

## Test plan
- Issue 4 ops (TAG_WIDTH=2), tags 0,1,2,3 → `issue_ready_o`=0, `count_o`=4; a 5th issue is held.
- Complete tags 2,0,3,1 with results 0xA2,0xA0,0xA3,0xA1 → retire order 0xA0,0xA1,0xA2,0xA3 on consecutive cycles after tag 1 completes.
- Full buffer, `ret_ready_i`=1, issue waiting → retire at edge N, issue accepted in cycle N+1 with tag 0 (wrapped), `count_o` back to 4.
- Completion with tag 3 when only tags 0–1 are allocated → `err_o`=1 sticky, no change to `ret_valid_o`/`count_o`.
- 3 entries allocated, 1 done, `flush_i` plus a completion in the same cycle → next cycle `count_o`=0, `ret_valid_o`=0, `err_o` unchanged, next issue tag 0.
- With `FPNEW_ROB_FFLAGS_EN`: retire statuses 5'b00001 then 5'b10000 → `fflags_o`=5'b10001; pulse `fflags_clr_i` → 0.
